meter_peak_writer: RTL
======================

# meter_peak_writer

Per-channel peak-level metering engine that produces the contents of the metering RAM (meter_mem), which the SPI memory interface reads back for the host. Once per audio frame it samples the 8 ADAT input and 8 ADAT output channels, tracks the absolute peak of each over a window of frames, and publishes each window into one of two ping-pong banks. It finishes every window by writing a status word, so the host always reads a complete, consistent bank.

## Interface
- IO_WIDTH, 24: audio sample width, two's complement.
- NUM_IN, 8: input channels; NUM_OUT, 8: output channels; NUM_CH = NUM_IN+NUM_OUT.
- WINDOW_FRAMES, 1024: frames per metering window; legal range 1..65535.
- METER_ADDR_WIDTH, 8: meter RAM address width.
- BANK_STRIDE, 32: address offset of bank 1 relative to bank 0; must be >= NUM_CH.
- STATUS_ADDR, 255: address of the status word.

Ports:
- dsp_clk  in  1  DSP clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per sample frame.
- audio_inputs  in  [0:NUM_IN-1][IO_WIDTH]  ADAT receive channels.
- audio_outputs  in  [0:NUM_OUT-1][IO_WIDTH]  ADAT transmit channels.
- clear  in  1  synchronous clear of peaks, window count and overrun.
- meter_wr_addr  out  METER_ADDR_WIDTH  meter RAM write address.
- meter_wr_data  out  IO_WIDTH  meter RAM write data.
- meter_wr_en  out  1  meter RAM write strobe.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  sticky; set when a frame_tick arrives while busy.

## Operation
- Channel index: 0..7 = audio_inputs[0..7]; 8..15 = audio_outputs[0..7].
- State machine with three states: IDLE, ACCUM, FLUSH.
- IDLE + frame_tick (no clear):
  - latch all NUM_CH samples into a snapshot register;
  - set ch=0 and go to ACCUM.
- ACCUM, one channel per cycle:
  - a = |snapshot[ch]|; the most negative value -2^(IO_WIDTH-1) saturates to 2^(IO_WIDTH-1)-1;
  - peak[ch] <= max(peak[ch], a).
- Leaving ACCUM after ch = NUM_CH-1: increment frame_cnt.
  - If frame_cnt was WINDOW_FRAMES-1, wrap it to 0 and go to FLUSH.
  - Otherwise return to IDLE.
- FLUSH issues NUM_CH+1 consecutive writes:
  - writes 0..NUM_CH-1: addr = wbank*BANK_STRIDE+ch, data = peak[ch]; clear each peak[ch] to 0 as it is written;
  - final write: addr = STATUS_ADDR, data = {7'b0, wbank, seq+1}; seq <= seq+1 (16-bit, wraps 65535->0); wbank toggles;
  - then return to IDLE.
- frame_tick while busy is dropped, frame_cnt is unchanged, and overrun is set.
- clear:
  - zeros peaks, frame_cnt and overrun, and aborts to IDLE from any state;
  - meter_wr_en is low from the next cycle;
  - seq and wbank are preserved;
  - the status word is not written, so the host keeps reading the previous valid bank.
- clear and frame_tick in the same cycle: clear wins; the tick is dropped and overrun is not set.

## Timing
- Reset values:
  - outputs: meter_wr_addr=0, meter_wr_data=0, meter_wr_en=0, busy=0, overrun=0;
  - internal: state=IDLE, peaks=0, frame_cnt=0, seq=0, wbank=0.
- Tick sampled at edge k:
  - snapshot captured at edge k;
  - ACCUM updates happen at edges k+1..k+NUM_CH;
  - busy is high from after edge k.
- Non-window frame: busy falls after edge k+NUM_CH.
- Window-end frame, all write outputs registered:
  - meter_wr_en is high for exactly NUM_CH+1 consecutive cycles, after edges k+NUM_CH+1 .. k+2*NUM_CH+1;
  - the status write is last;
  - busy falls after edge k+2*NUM_CH+2.
- Maximum busy time is 34 cycles with defaults, far inside the 2048-cycle frame at 98.304 MHz.
- Reset asserted mid-FLUSH: outputs drop immediately (asynchronous).
- The host-visible status first appears after the first full window: bank 0, seq 1.

## Test plan
- Peak tracking, WINDOW_FRAMES=4:
  - stimulus: ch0 takes 0x000100, 0x7FFFFF, 0x000010, 0x000001 on four ticks; ch8 = 0xFFFF00 (-256) constant;
  - required: addr 0 = 0x7FFFFF, addr 8 = 0x000100, addr 255 = 0x000001, 17 consecutive wr_en cycles.
- Saturation: ch3 = 0x800000 for one window -> addr 3 = 0x7FFFFF.
- Ping-pong, WINDOW_FRAMES=1, three ticks:
  - data writes land at 0..15, then 32..47, then 0..15;
  - status sequence 0x000001, 0x010002, 0x000003;
  - peaks are zero at the start of each window.
- Overrun:
  - a second tick 5 cycles after the first: overrun=1, frame_cnt advances once;
  - then clear: overrun=0.
- Clear mid-FLUSH after 6 data writes:
  - wr_en is low from the next cycle and no status write occurs;
  - the next window writes bank 0 again with seq unchanged+1;
  - clear and tick in the same cycle: no capture, overrun stays 0.
- Reset mid-ACCUM:
  - all outputs 0 immediately;
  - the first window after release produces status 0x000001.

Source files
------------

// File: rtl/meter_peak_writer_if.sv
// Meter RAM write bus: address, data and write strobe produced by the
// peak metering engine and consumed by the meter RAM.
interface meter_peak_writer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 24
);
    logic [ADDR_WIDTH-1:0] meter_wr_addr;
    logic [DATA_WIDTH-1:0] meter_wr_data;
    logic                  meter_wr_en;

    modport master (
        output meter_wr_addr,
        output meter_wr_data,
        output meter_wr_en
    );

    modport slave (
        input meter_wr_addr,
        input meter_wr_data,
        input meter_wr_en
    );
endinterface

// File: rtl/meter_peak_writer.sv
// Per-channel peak metering engine. Once per frame it snapshots all input
// and output channels, folds their absolute values into per-channel peaks,
// and at the end of each window flushes the peaks into one of two ping-pong
// banks of the meter RAM, finishing with a status word {bank, seq}.
module meter_peak_writer #(
    parameter int IO_WIDTH         = 24,
    parameter int NUM_IN           = 8,
    parameter int NUM_OUT          = 8,
    parameter int WINDOW_FRAMES    = 1024,
    parameter int METER_ADDR_WIDTH = 8,
    parameter int BANK_STRIDE      = 32,
    parameter int STATUS_ADDR      = 255
) (
    input  logic                               dsp_clk,
    input  logic                               reset_n,
    input  logic                               frame_tick,
    input  logic [0:NUM_IN-1][IO_WIDTH-1:0]    audio_inputs,
    input  logic [0:NUM_OUT-1][IO_WIDTH-1:0]   audio_outputs,
    input  logic                               clear,
    meter_peak_writer_if.master                meter,
    output logic                               busy,
    output logic                               overrun
);
    localparam int NUM_CH = NUM_IN + NUM_OUT;
    // Step counter must reach NUM_CH+1 (status write, then the exit step).
    localparam int CH_W   = $clog2(NUM_CH + 2);
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CH_W-1:0]     LAST_CH     = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0]     STATUS_STEP = CH_W'(NUM_CH);
    localparam logic [CH_W-1:0]     DONE_STEP   = CH_W'(NUM_CH + 1);
    localparam logic [15:0]         LAST_FRAME  = 16'(WINDOW_FRAMES - 1);
    localparam logic [IO_WIDTH-1:0] MAX_POS     = {1'b0, {(IO_WIDTH-1){1'b1}}};
    localparam logic [IO_WIDTH-1:0] MIN_NEG     = {1'b1, {(IO_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [CH_W-1:0]         ch_reg;
    logic [15:0]             frame_cnt_reg;
    logic [15:0]             seq_reg;
    logic                    wbank_reg;
    logic                    overrun_reg;

    logic [METER_ADDR_WIDTH-1:0] wr_addr_reg, wr_addr_next;
    logic [IO_WIDTH-1:0]         wr_data_reg, wr_data_next;
    logic                        wr_en_reg, wr_en_next;

    logic [IO_WIDTH-1:0]     snap_bus [NUM_CH];
    logic [IO_WIDTH-1:0]     peak_bus [NUM_CH];

    logic [IDX_W-1:0]        ch_idx;
    logic [IO_WIDTH-1:0]     cur_sample;
    logic [IO_WIDTH-1:0]     cur_abs;
    logic                    capture;
    logic                    accum_last;
    logic [15:0]             seq_plus;
    logic [METER_ADDR_WIDTH-1:0] bank_base;
    logic [IO_WIDTH-1:0]     status_word;

    assign ch_idx      = ch_reg[IDX_W-1:0];
    assign capture     = (state_reg == IDLE) && frame_tick && !clear;
    assign accum_last  = (state_reg == ACCUM) && (ch_reg == LAST_CH);
    assign seq_plus    = seq_reg + 16'd1;
    assign bank_base   = wbank_reg ? METER_ADDR_WIDTH'(BANK_STRIDE) : '0;
    assign status_word = IO_WIDTH'({wbank_reg, seq_plus});

    // Absolute value of the channel being accumulated; the most negative code saturates.
    always_comb begin
        cur_sample = snap_bus[ch_idx];
        if (cur_sample == MIN_NEG) begin
            cur_abs = MAX_POS;
        end else if (cur_sample[IO_WIDTH-1]) begin
            cur_abs = -cur_sample;
        end else begin
            cur_abs = cur_sample;
        end
    end

    // Per-channel snapshot and peak registers; channels 0..NUM_IN-1 are inputs, the rest outputs.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [IO_WIDTH-1:0] sample_in;
            logic [IO_WIDTH-1:0] snap_reg;
            logic [IO_WIDTH-1:0] peak_reg;

            if (gi < NUM_IN) begin : g_in
                assign sample_in = audio_inputs[gi];
            end else begin : g_out
                assign sample_in = audio_outputs[gi - NUM_IN];
            end

            // Capture this channel's sample when a frame is accepted.
            always_ff @(posedge dsp_clk or negedge reset_n) begin
                if (!reset_n) begin
                    snap_reg <= '0;
                end else if (capture) begin
                    snap_reg <= sample_in;
                end
            end

            // Track the running peak; zero it on clear or once flushed to RAM.
            always_ff @(posedge dsp_clk or negedge reset_n) begin
                if (!reset_n) begin
                    peak_reg <= '0;
                end else if (clear) begin
                    peak_reg <= '0;
                end else if (state_reg == ACCUM && ch_reg == CH_W'(gi)) begin
                    if (cur_abs > peak_reg) begin
                        peak_reg <= cur_abs;
                    end
                end else if (state_reg == FLUSH && ch_reg == CH_W'(gi)) begin
                    peak_reg <= '0;
                end
            end

            assign snap_bus[gi] = snap_reg;
            assign peak_bus[gi] = peak_reg;
        end
    endgenerate

    // State register.
    always_ff @(posedge dsp_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; clear aborts to IDLE from anywhere.
    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (frame_tick) begin
                        state_next = ACCUM;
                    end
                end
                ACCUM: begin
                    if (ch_reg == LAST_CH) begin
                        state_next = (frame_cnt_reg == LAST_FRAME) ? FLUSH : IDLE;
                    end
                end
                FLUSH: begin
                    if (ch_reg == DONE_STEP) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output logic: next values for the registered RAM write port.
    always_comb begin
        wr_en_next   = 1'b0;
        wr_addr_next = '0;
        wr_data_next = '0;
        if (!clear && state_reg == FLUSH) begin
            if (ch_reg < STATUS_STEP) begin
                wr_en_next   = 1'b1;
                wr_addr_next = bank_base + METER_ADDR_WIDTH'(ch_reg);
                wr_data_next = peak_bus[ch_idx];
            end else if (ch_reg == STATUS_STEP) begin
                wr_en_next   = 1'b1;
                wr_addr_next = METER_ADDR_WIDTH'(STATUS_ADDR);
                wr_data_next = status_word;
            end
        end
    end

    // Registered RAM write port.
    always_ff @(posedge dsp_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    // Step counter, window frame counter, bank/sequence bookkeeping and sticky overrun.
    always_ff @(posedge dsp_clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_reg        <= '0;
            frame_cnt_reg <= '0;
            seq_reg       <= '0;
            wbank_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (state_next != state_reg) begin
                ch_reg <= '0;
            end else if (state_reg != IDLE) begin
                ch_reg <= ch_reg + CH_W'(1);
            end

            if (clear) begin
                frame_cnt_reg <= '0;
            end else if (accum_last) begin
                frame_cnt_reg <= (frame_cnt_reg == LAST_FRAME) ? 16'd0 : frame_cnt_reg + 16'd1;
            end

            if (!clear && state_reg == FLUSH && ch_reg == STATUS_STEP) begin
                seq_reg   <= seq_plus;
                wbank_reg <= ~wbank_reg;
            end

            if (clear) begin
                overrun_reg <= 1'b0;
            end else if (frame_tick && state_reg != IDLE) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign meter.meter_wr_addr = wr_addr_reg;
    assign meter.meter_wr_data = wr_data_reg;
    assign meter.meter_wr_en   = wr_en_reg;
    assign busy                = (state_reg != IDLE);
    assign overrun             = overrun_reg;

endmodule
